// File: rtl/edge_event_arbiter.sv
// Rising-edge detector for N lines with one-deep pending queue per line,
// served round-robin through a registered valid/ready event slot.
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   en,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  input  logic           ev_ready,
  output logic [N-1:0]   ev_overrun,
  input  logic           ovr_clr
);

  logic [N-1:0]   prev_q;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   ovr_q, ovr_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [N-1:0]   edge_v;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;
  logic [IDW-1:0] sel;
  logic           slot_free;
  logic           load;
  logic [N-1:0]   load_mask;

  assign edge_v    = a & ~prev_q & en;
  assign slot_free = ~valid_q | ev_ready;

  // Rotate pending so bit 0 is the channel at ptr, then priority-pick.
  assign dbl = {pend_q, pend_q} >> ptr_q;
  assign rot = dbl[N-1:0];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
  end

  assign sum = {1'b0, ptr_q} + {1'b0, off};

  always_comb begin
    sel = sum[IDW-1:0];
    if (sum >= (IDW+1)'(N)) begin
      sel = IDW'(sum - (IDW+1)'(N));
    end
  end

  assign load      = slot_free & found;
  assign load_mask = load ? (N'(1) << sel) : '0;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      id_d    = sel;
      ptr_d   = (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // A same-cycle re-edge on the channel being loaded keeps it pending.
  always_comb begin
    pend_d = ((pend_q & ~load_mask) | edge_v) & en;
    ovr_d  = (ovr_clr ? '0 : ovr_q) | (edge_v & pend_q & ~load_mask);
  end

  always_ff @(posedge clk) begin
    prev_q <= a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      ovr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ev_valid   = valid_q;
  assign ev_id      = id_q;
  assign ev_overrun = ovr_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed cycle checks plus an
// expected-ID scoreboard popped on every accepted event.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] en;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_ready;
  logic [3:0] ev_overrun;
  logic       ovr_clr;

  int checks = 0;
  int errors = 0;
  int sb[$];

  edge_event_arbiter #(.N(4), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .en         (en),
    .ev_valid   (ev_valid),
    .ev_id      (ev_id),
    .ev_ready   (ev_ready),
    .ev_overrun (ev_overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Handshake completes at the next posedge; pop the expected ID now.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'(ev_id), 32'hFF);
      else                chk("sb_id", 32'(ev_id), 32'(sb.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; a = 4'b0010; en = 4'hF; ev_ready = 1'b1; ovr_clr = 1'b0;
    ticks(2);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_ovr", 32'(ev_overrun), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(ev_valid), 0);
    end
    chk("hold_ovr", 32'(ev_overrun), 0);

    // single edge latency
    a = 4'b0000; tick();
    a = 4'b0100; sb.push_back(2);
    tick();
    chk("lat_t", 32'(ev_valid), 0);
    tick();
    chk("lat_valid", 32'(ev_valid), 1);
    chk("lat_id", 32'(ev_id), 2);
    tick();
    chk("lat_drop", 32'(ev_valid), 0);
    a = 4'b0000; tick();

    // round robin from ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    a = 4'hF;
    for (int i = 0; i < 4; i++) sb.push_back(i);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_valid", 32'(ev_valid), 1);
      chk("rr_id", 32'(ev_id), 32'(i));
    end
    tick();
    chk("rr_end", 32'(ev_valid), 0);
    a = 4'b0000; tick();

    // ch2 single event leaves ptr=3; then ch0+ch3 together
    a = 4'b0100; sb.push_back(2);
    ticks(3);
    a = 4'b0000; tick();
    a = 4'b1001; sb.push_back(3); sb.push_back(0);
    ticks(2);
    chk("wrap_id0", 32'(ev_id), 3);
    tick();
    chk("wrap_id1", 32'(ev_id), 0);
    tick();
    chk("wrap_end", 32'(ev_valid), 0);
    a = 4'b0000; tick();

    // backpressure
    ev_ready = 1'b0;
    a = 4'b0010; sb.push_back(1); sb.push_back(3);
    ticks(2);
    a = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(ev_valid), 1);
      chk("bp_id", 32'(ev_id), 1);
    end
    ev_ready = 1'b1;
    tick();
    chk("bp_next_valid", 32'(ev_valid), 1);
    chk("bp_next_id", 32'(ev_id), 3);
    tick();
    chk("bp_end", 32'(ev_valid), 0);
    a = 4'b0000; tick();

    // overrun: slot holds ch0, ch1 pulses twice
    ev_ready = 1'b0;
    a = 4'b0001; sb.push_back(0);
    ticks(2);
    chk("ov_hold_id", 32'(ev_id), 0);
    a = 4'b0011; tick();
    a = 4'b0001; tick();
    chk("ov_none", 32'(ev_overrun), 0);
    a = 4'b0011; tick();
    chk("ov_set", 32'(ev_overrun), 4'b0010);
    ticks(2);
    chk("ov_sticky", 32'(ev_overrun), 4'b0010);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ov_clr", 32'(ev_overrun), 0);
    a = 4'b0001; tick();
    a = 4'b0011; ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ov_set_wins", 32'(ev_overrun), 4'b0010);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ov_clr2", 32'(ev_overrun), 0);
    sb.push_back(1);
    ev_ready = 1'b1;
    ticks(3);
    chk("ov_drain", 32'(ev_valid), 0);
    a = 4'b0000; tick();
    chk("ov_sb_empty", 32'(sb.size()), 0);

    // disabled line rises
    en = 4'b1011; a = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_off_valid", 32'(ev_valid), 0);
    end
    a = 4'b0000; en = 4'hF; tick();

    // pending ch2 dropped by en while slot busy with ch0
    ev_ready = 1'b0;
    a = 4'b0001; sb.push_back(0);
    ticks(2);
    a = 4'b0101; tick();
    en = 4'b1011; tick();
    en = 4'hF; tick();
    chk("drop_hold_id", 32'(ev_id), 0);
    ev_ready = 1'b1;
    tick();
    chk("drop_none", 32'(ev_valid), 0);
    tick();
    chk("drop_none2", 32'(ev_valid), 0);
    a = 4'b0000; tick();

    // reset while valid
    ev_ready = 1'b0;
    a = 4'b1000;
    ticks(2);
    chk("mr_valid", 32'(ev_valid), 1);
    chk("mr_id", 32'(ev_id), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_cleared", 32'(ev_valid), 0);
    ev_ready = 1'b1;
    ticks(2);
    chk("mr_after", 32'(ev_valid), 0);
    chk("mr_ovr", 32'(ev_overrun), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Scheduler for the positive-edge-detection function across N independent input lines.
- Detects a rising edge on each enabled line and queues one pending event per line.
- Serves pending events one at a time, round-robin, on a registered valid/ready event port, so a single downstream consumer can service all lines.
- Flags events lost because a line re-fired while its previous event was still queued.

Parameters:
- N, 4, number of input lines/channels (2..16).
- IDW, 2, width of channel ID; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  N  monitored lines; already synchronous to clk.
- en  input  N  per-channel enable for edge detection.
- ev_valid  output  1  event slot holds a valid event.
- ev_id  output  IDW  channel number of the held event.
- ev_ready  input  1  consumer accepts the event this cycle.
- ev_overrun  output  N  sticky per-channel lost-event flag.
- ovr_clr  input  1  clears all ev_overrun bits.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and named rst on clk.
- prev[N-1:0] <= a every cycle, including while rst=1. A line held high through reset therefore produces no edge.
- Edge detection:
  - edge[i] = a[i] & ~prev[i] & en[i], evaluated combinationally.
  - prev tracks a regardless of en. Enabling a line that is already high produces no event.
- Reset values: pending=0, ev_valid=0, ev_id=0, ev_overrun=0, rr pointer ptr=0.
- Output slot:
  - The slot is free when ev_valid=0, or when ev_valid=1 and ev_ready=1 (same-cycle refill is allowed).
  - When free and any pending bit is set, load the first pending channel searching ptr, ptr+1, ... with wrap mod N.
  - On load: ev_valid<=1, ev_id<=i, pending[i]<=0, ptr<=(i+1) mod N.
  - When free and nothing is pending: ev_valid<=0. ev_id holds its last value.
  - While ev_valid=1 and ev_ready=0, ev_valid and ev_id are held stable.
- Latency and throughput:
  - A rising edge first sampled at posedge t sets pending at t.
  - The earliest load is at posedge t+1, so ev_valid is visible after t+1 (2-cycle edge-to-valid latency).
  - Sustained throughput is 1 event/cycle while ev_ready=1.
- pending[i] next-state:
  - Set by edge[i].
  - Cleared by load of channel i.
  - If edge[i] and load of i occur in the same cycle: pending[i] stays 1 and no overrun is flagged.
  - en[i]=0 clears pending[i] on the next edge. An event already in the slot is not retracted.
- ev_overrun[i]:
  - Set when edge[i]=1, pending[i]=1, and channel i is not being loaded that cycle.
  - Cleared by ovr_clr. If set and ovr_clr coincide, set wins.
- Only channel 0..N-1 IDs are produced. The pointer wraps N-1 -> 0.
- Reset mid-operation:
  - ev_valid is 0 after the reset edge; pending and overrun are discarded.
  - prev is reloaded from a.
- ev_ready while ev_valid=0 is ignored.

Test Plan:
- Reset and hold-high:
  - Stimulus: rst=1 for 2 cycles with a=4'b0010, then release and hold.
  - Required: ev_valid stays 0 and ev_overrun=0.
- Single edge latency:
  - Stimulus: ev_ready=1, en=4'hF; a[2] 0->1 sampled at posedge t.
  - Required: ev_valid=1 with ev_id=2 after posedge t+1 for exactly one cycle, then ev_valid=0.
- Round-robin fairness:
  - Stimulus: a 0->4'hF in one cycle, ev_ready=1.
  - Required: ev_id sequence 0,1,2,3 on four consecutive cycles.
  - Stimulus: after ptr=3, a[0] and a[3] edge together.
  - Required: order 3 then 0.
- Backpressure:
  - Stimulus: ev_ready=0, edges on ch1 then ch3.
  - Required: ev_id=1 held stable; after ev_ready=1, the next cycle shows ev_id=3, then ev_valid=0.
- Overrun and clear:
  - Stimulus: ev_ready=0 with the slot holding ch0; ch1 edges twice (pulse 1,0,1).
  - Required: ev_overrun=4'b0010 sticky.
  - Stimulus: ovr_clr=1 for one cycle.
  - Required: ev_overrun=0.
  - Stimulus: an edge coinciding with ovr_clr.
  - Required: the bit is set.
- Enable and mid-op reset:
  - Stimulus: en[2]=0 while a[2] rises.
  - Required: no event.
  - Stimulus: a[2] pending, then en[2] cleared.
  - Required: pending dropped, no event emitted.
  - Stimulus: rst pulse while ev_valid=1.
  - Required: ev_valid=0 after the reset edge.
